// File: rtl/sync_filter_bank_if.sv
// rtl/sync_filter_bank_if.sv - signal bundle between the pin-side synchronizer bank and its user
// Purpose: groups the per-channel async inputs, controls and filtered outputs.
// Signals:
//   async_in  [CHANNELS]  raw asynchronous pin levels
//   filter_en            1 = glitch filter active, 0 = bypass
//   evt_clr   [CHANNELS]  per-channel clear of evt_pend/evt_ovf
//   filt_out  [CHANNELS]  synchronized, filtered level
//   rise/fall [CHANNELS]  one-cycle edge pulses on filt_out
//   evt_pend  [CHANNELS]  sticky transition flag
//   evt_ovf   [CHANNELS]  sticky transition-while-pending flag
// Modports: master drives inputs of the bank, slave is the bank itself.
interface sync_filter_bank_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] async_in;
  logic                filter_en;
  logic [CHANNELS-1:0] evt_clr;
  logic [CHANNELS-1:0] filt_out;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] evt_pend;
  logic [CHANNELS-1:0] evt_ovf;

  modport master (
    output async_in, filter_en, evt_clr,
    input  filt_out, rise, fall, evt_pend, evt_ovf
  );

  modport slave (
    input  async_in, filter_en, evt_clr,
    output filt_out, rise, fall, evt_pend, evt_ovf
  );
endinterface

// File: rtl/sync_filter_bank.sv
// rtl/sync_filter_bank.sv - multi-channel pin synchronizer with glitch filter, edge pulses and sticky events
// Purpose: the only sampler of the asynchronous input pins; every output is registered.
// Ports:
//   CLK  sole clock, rising edge
//   RST  asynchronous active-high reset
//   bus  sync_filter_bank_if.slave (async_in, filter_en, evt_clr in; filt_out, rise, fall, evt_pend, evt_ovf out)
module sync_filter_bank #(
  parameter int   CHANNELS  = 4,
  parameter int   STAGES    = 2,
  parameter int   FILTER    = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  sync_filter_bank_if.slave bus
);
  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  // chain_q[ch][0] is the first capture flop, [STAGES-1] is the "sync" stage
  logic [STAGES-1:0]   chain_q [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0] rise_q, fall_q;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] sync_w;
  logic [CHANNELS-1:0] trans_w;
  logic                fe_q;

  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      sync_w[ch] = chain_q[ch][STAGES-1];
    end
  end

  // Filter: the counter tracks how many consecutive edges sync has disagreed
  // with filt_out. The edge on which filter_en turns on only clears, so the
  // full FILTER-cycle qualification always restarts from zero.
  always_comb begin
    filt_d = filt_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      cnt_d[ch] = '0;
      if (!bus.filter_en) begin
        filt_d[ch] = sync_w[ch];
      end else if (!fe_q) begin
        cnt_d[ch] = '0;
      end else if (sync_w[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          filt_d[ch] = sync_w[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // A same-edge transition wins over evt_clr for pend; ovf is only set when
  // the channel was already pending and no clear is being applied.
  always_comb begin
    trans_w = filt_d ^ filt_q;
    pend_d  = trans_w | (pend_q & ~bus.evt_clr);
    ovf_d   = ~bus.evt_clr & (ovf_q | (trans_w & pend_q));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        chain_q[ch] <= {STAGES{RESET_VAL}};
        cnt_q[ch]   <= '0;
      end
      filt_q <= {CHANNELS{RESET_VAL}};
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      fe_q   <= 1'b1;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        chain_q[ch] <= {chain_q[ch][STAGES-2:0], bus.async_in[ch]};
        cnt_q[ch]   <= cnt_d[ch];
      end
      filt_q <= filt_d;
      rise_q <= filt_d & ~filt_q;
      fall_q <= ~filt_d & filt_q;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      fe_q   <= bus.filter_en;
    end
  end

  assign bus.filt_out = filt_q;
  assign bus.rise     = rise_q;
  assign bus.fall     = fall_q;
  assign bus.evt_pend = pend_q;
  assign bus.evt_ovf  = ovf_q;
endmodule

// File: tb/tb_sync_filter_bank.sv
// tb/tb_sync_filter_bank.sv - self-checking bench for sync_filter_bank
module tb_sync_filter_bank;
  localparam int ST   = 2;
  localparam int FILT = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  sync_filter_bank_if #(.CHANNELS(4)) bus ();
  sync_filter_bank_if #(.CHANNELS(8)) bus8 ();

  sync_filter_bank #(.CHANNELS(4), .STAGES(ST), .FILTER(FILT), .RESET_VAL(1'b0)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );
  sync_filter_bank #(.CHANNELS(8), .STAGES(3), .FILTER(1), .RESET_VAL(1'b0)) dut8 (
    .CLK(CLK), .RST(RST), .bus(bus8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      @(negedge CLK);
    end
  endtask

  // Behavioural model: sync is the input vector sampled ST edges ago (history
  // queue); each channel keeps a run length of edges its sync level has
  // disagreed with the filtered level, and adopts it once that run hits FILT.
  logic [3:0]      m_hist[$];
  logic [3:0]      m_filt, m_rise, m_fall, m_pend, m_ovf;
  logic [3:0][7:0] m_run;
  logic            m_fe_prev;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_hist.delete();
      for (int i = 0; i < ST; i++) m_hist.push_back(4'b0000);
      m_filt    <= '0;
      m_rise    <= '0;
      m_fall    <= '0;
      m_pend    <= '0;
      m_ovf     <= '0;
      m_run     <= '0;
      m_fe_prev <= 1'b1;
    end else begin : step
      automatic logic [3:0]      s     = m_hist[ST-1];
      automatic logic [3:0]      nf    = m_filt;
      automatic logic [3:0][7:0] nrun  = '0;
      automatic logic [3:0]      npend = m_pend;
      automatic logic [3:0]      novf  = m_ovf;
      for (int ch = 0; ch < 4; ch++) begin
        if (!bus.filter_en) begin
          nf[ch] = s[ch];
        end else if (m_fe_prev && s[ch] != m_filt[ch]) begin
          if (int'(m_run[ch]) + 1 >= FILT) nf[ch] = s[ch];
          else nrun[ch] = m_run[ch] + 8'd1;
        end
        if (nf[ch] != m_filt[ch]) begin
          npend[ch] = 1'b1;
          if (bus.evt_clr[ch]) novf[ch] = 1'b0;
          else if (m_pend[ch]) novf[ch] = 1'b1;
        end else if (bus.evt_clr[ch]) begin
          npend[ch] = 1'b0;
          novf[ch]  = 1'b0;
        end
      end
      m_rise    <= nf & ~m_filt;
      m_fall    <= m_filt & ~nf;
      m_filt    <= nf;
      m_pend    <= npend;
      m_ovf     <= novf;
      m_run     <= nrun;
      m_fe_prev <= bus.filter_en;
      m_hist.push_front(bus.async_in);
      void'(m_hist.pop_back());
    end
  end

  always @(negedge CLK) begin
    if (started && !RST) begin
      chk("mdl_filt", {4'b0, bus.filt_out}, {4'b0, m_filt});
      chk("mdl_rise", {4'b0, bus.rise},     {4'b0, m_rise});
      chk("mdl_fall", {4'b0, bus.fall},     {4'b0, m_fall});
      chk("mdl_pend", {4'b0, bus.evt_pend}, {4'b0, m_pend});
      chk("mdl_ovf",  {4'b0, bus.evt_ovf},  {4'b0, m_ovf});
      chk("mdl_excl", {4'b0, bus.rise & bus.fall}, 8'h00);
    end
  end

  initial begin
    bus.async_in   = '0;
    bus.filter_en  = 1'b1;
    bus.evt_clr    = '0;
    bus8.async_in  = '0;
    bus8.filter_en = 1'b1;
    bus8.evt_clr   = '0;
    #1 RST = 1'b1;
    #1;
    chk("rst_filt", {4'b0, bus.filt_out}, 8'h00);
    chk("rst_pend", {4'b0, bus.evt_pend}, 8'h00);
    chk("rst_ovf",  {4'b0, bus.evt_ovf},  8'h00);
    @(negedge CLK);
    RST = 1'b0;
    started = 1'b1;

    // latency with filter on: update after edge 5
    bus.async_in[0] = 1'b1;
    tick(5);
    chk("lat_e4_filt", {4'b0, bus.filt_out}, 8'h00);
    tick();
    chk("lat_e5_filt", {4'b0, bus.filt_out}, 8'h01);
    chk("lat_e5_rise", {4'b0, bus.rise},     8'h01);
    chk("lat_e5_pend", {4'b0, bus.evt_pend}, 8'h01);
    tick();
    chk("lat_e6_rise", {4'b0, bus.rise},     8'h00);

    // glitch of 3 cycles on ch1 is swallowed
    bus.async_in[1] = 1'b1;
    tick(3);
    bus.async_in[1] = 1'b0;
    tick(8);
    chk("glitch_filt", {4'b0, bus.filt_out}, 8'h01);
    chk("glitch_pend", {4'b0, bus.evt_pend}, 8'h01);

    // bypass: fall after edge 2, second transition sets ovf
    bus.filter_en   = 1'b0;
    bus.async_in[0] = 1'b0;
    tick(2);
    chk("byp_e1_filt", {4'b0, bus.filt_out}, 8'h01);
    tick();
    chk("byp_e2_filt", {4'b0, bus.filt_out}, 8'h00);
    chk("byp_e2_fall", {4'b0, bus.fall},     8'h01);
    chk("byp_ovf",     {4'b0, bus.evt_ovf},  8'h01);

    // clear on the same edge as a third transition: pend stays, ovf clears
    bus.async_in[0] = 1'b1;
    tick(2);
    bus.evt_clr[0] = 1'b1;
    tick();
    bus.evt_clr[0] = 1'b0;
    chk("clr_tr_rise", {4'b0, bus.rise},     8'h01);
    chk("clr_tr_pend", {4'b0, bus.evt_pend}, 8'h01);
    chk("clr_tr_ovf",  {4'b0, bus.evt_ovf},  8'h00);
    bus.evt_clr = 4'b0011;
    tick();
    bus.evt_clr = '0;
    chk("clr_pend", {4'b0, bus.evt_pend}, 8'h00);

    // filter re-enabled on the edge sync differs: full count restarts
    bus.async_in[3] = 1'b1;
    tick(2);
    bus.filter_en = 1'b1;
    tick();
    chk("restart_e2", {4'b0, bus.filt_out}, 8'h01);
    tick(3);
    chk("restart_e5", {4'b0, bus.filt_out}, 8'h01);
    tick();
    chk("restart_e6", {4'b0, bus.filt_out}, 8'h09);
    chk("restart_rise", {4'b0, bus.rise},   8'h08);

    // bypass mid-count passes sync straight through
    bus.async_in[2] = 1'b1;
    tick(4);
    chk("mid_e3", {4'b0, bus.filt_out}, 8'h09);
    bus.filter_en = 1'b0;
    tick();
    bus.filter_en = 1'b1;
    chk("mid_byp", {4'b0, bus.filt_out}, 8'h0d);

    // asynchronous reset mid-count
    bus.async_in = 4'b1111;
    tick(3);
    #2 RST = 1'b1;
    #1;
    chk("arst_filt", {4'b0, bus.filt_out}, 8'h00);
    chk("arst_rise", {4'b0, bus.rise},     8'h00);
    chk("arst_fall", {4'b0, bus.fall},     8'h00);
    chk("arst_pend", {4'b0, bus.evt_pend}, 8'h00);
    chk("arst_ovf",  {4'b0, bus.evt_ovf},  8'h00);
    @(negedge CLK);
    RST = 1'b0;
    tick(5);
    chk("post_rst_e4", {4'b0, bus.filt_out}, 8'h00);
    tick();
    chk("post_rst_e5", {4'b0, bus.filt_out}, 8'h0f);
    chk("post_rst_rise", {4'b0, bus.rise},   8'h0f);

    // 8 channels, 3 stages, FILTER=1
    bus8.async_in = 8'hA5;
    tick(3);
    chk("ch8_e2", bus8.filt_out, 8'h00);
    tick();
    chk("ch8_e3_filt", bus8.filt_out, 8'hA5);
    chk("ch8_e3_rise", bus8.rise,     8'hA5);
    chk("ch8_e3_pend", bus8.evt_pend, 8'hA5);
    bus8.async_in = 8'h3C;
    tick(3);
    chk("ch8_b_e2", bus8.filt_out, 8'hA5);
    tick();
    chk("ch8_b_filt", bus8.filt_out, 8'h3C);
    chk("ch8_b_rise", bus8.rise,     8'h18);
    chk("ch8_b_fall", bus8.fall,     8'h81);
    chk("ch8_b_pend", bus8.evt_pend, 8'hBD);
    chk("ch8_b_ovf",  bus8.evt_ovf,  8'h81);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
